tdc_meas_ctrl: RTL and testbench

Measurement sequencer for the tapped-delay-line TDC: accepts a measurement request, arms and clears the delay-line front end, and times the start/stop hits with a coarse clock-cycle counter. It combines the coarse count with the two fine tap codes into one interval in tap units. The result is delivered on a valid/ready handshake. It sits between the TDC front end (`tdc_top` plus hit synchronisers) and the host/readout logic.

---
 rtl/tdc_pkg.sv | 26 ++
 rtl/tdc_coarse_cnt.sv | 30 +++
 rtl/tdc_meas_ctrl.sv | 149 ++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types for the TDC measurement path: controller states, result record
// and the fine-code width helper.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_START,
    COUNT,
    RESULT
  } tdc_ctrl_state_t;

  // Widest interval any supported configuration produces; the readout block
  // stores results in this record.
  localparam int TDC_RES_MAX_W = 32;

  typedef struct packed {
    logic [TDC_RES_MAX_W-1:0] interval;
    logic                     timeout;
  } tdc_result_t;

  function automatic int fine_width(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

endpackage

// File: rtl/tdc_coarse_cnt.sv
// Cycle counter shared by the start-wait and coarse-count phases. A clear loads
// 1 so the value always equals the 1-based index of the current phase cycle.
module tdc_coarse_cnt #(
  parameter int CNT_W = 17,
  parameter int LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= CNT_W'(1);
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == CNT_W'(LIMIT));

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: arms the delay-line front end, times start/stop hits
// and delivers coarse*NUM_TAPS + start_fine - stop_fine on a valid/ready port.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int NUM_TAPS    = 32,
  parameter int COARSE_W    = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int FINE_W     = fine_width(NUM_TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       meas_req,
  output logic                       meas_busy,
  output logic                       tdc_clr,
  output logic                       tdc_arm,
  input  logic                       start_hit,
  input  logic [FINE_W-1:0]          start_fine,
  input  logic                       stop_hit,
  input  logic [FINE_W-1:0]          stop_fine,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COARSE_W+FINE_W-1:0] res_time,
  output logic                       res_timeout
);

  localparam int RES_W = COARSE_W + FINE_W;
  // One spare bit so the counter can reach TIMEOUT_CYC == 2**COARSE_W.
  localparam int CNT_W = COARSE_W + 1;

  tdc_ctrl_state_t  state_reg, state_next;
  logic [CNT_W-1:0] count;
  logic             phase_tc;
  logic             coarse_limit;
  logic             cnt_clr, cnt_en;
  logic             latch_start, load_res;

  logic [FINE_W-1:0]   start_fine_reg;
  logic [FINE_W-1:0]   fine_a;
  logic [COARSE_W-1:0] coarse_sel;
  logic [RES_W:0]      diff;
  logic [RES_W-1:0]    meas_time;
  logic [RES_W-1:0]    res_time_reg, res_time_next;
  logic                res_timeout_reg, res_timeout_next;

  tdc_coarse_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (phase_tc)
  );

  assign coarse_limit = (count == CNT_W'(TIMEOUT_CYC - 1));

  // Start and stop in the same cycle: coarse is 0 and the start code is taken
  // straight from the input since it has not been latched yet.
  always_comb begin
    fine_a     = (state_reg == WAIT_START) ? start_fine : start_fine_reg;
    coarse_sel = (state_reg == WAIT_START) ? '0 : count[COARSE_W-1:0];
    diff       = {1'b0, coarse_sel, fine_a} - (RES_W+1)'(stop_fine);
    meas_time  = diff[RES_W] ? '0 : diff[RES_W-1:0];
  end

  always_comb begin
    state_next       = state_reg;
    cnt_clr          = 1'b0;
    cnt_en           = 1'b0;
    latch_start      = 1'b0;
    load_res         = 1'b0;
    res_time_next    = meas_time;
    res_timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (meas_req) state_next = ARM;
      end
      ARM: begin
        cnt_clr    = 1'b1;
        state_next = WAIT_START;
      end
      WAIT_START: begin
        cnt_en = 1'b1;
        if (start_hit && stop_hit) begin
          load_res   = 1'b1;
          state_next = RESULT;
        end else if (start_hit) begin
          latch_start = 1'b1;
          cnt_clr     = 1'b1;
          state_next  = COUNT;
        end else if (phase_tc) begin
          load_res         = 1'b1;
          res_time_next    = '0;
          res_timeout_next = 1'b1;
          state_next       = RESULT;
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        if (stop_hit) begin
          load_res   = 1'b1;
          state_next = RESULT;
        end else if (coarse_limit) begin
          load_res         = 1'b1;
          res_time_next    = '0;
          res_timeout_next = 1'b1;
          state_next       = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_fine_reg  <= '0;
      res_time_reg    <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      if (latch_start) start_fine_reg <= start_fine;
      if (load_res) begin
        res_time_reg    <= res_time_next;
        res_timeout_reg <= res_timeout_next;
      end
    end
  end

  assign meas_busy   = (state_reg != IDLE);
  assign tdc_clr     = (state_reg == ARM);
  assign tdc_arm     = (state_reg == WAIT_START) || (state_reg == COUNT);
  assign res_valid   = (state_reg == RESULT);
  assign res_time    = res_time_reg;
  assign res_timeout = res_timeout_reg;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl with NUM_TAPS=32 and TIMEOUT_CYC=16.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas_req;
  logic        meas_busy;
  logic        tdc_clr;
  logic        tdc_arm;
  logic        start_hit;
  logic [4:0]  start_fine;
  logic        stop_hit;
  logic [4:0]  stop_fine;
  logic        res_valid;
  logic        res_ready;
  logic [20:0] res_time;
  logic        res_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl #(
    .NUM_TAPS    (32),
    .COARSE_W    (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_req    (meas_req),
    .meas_busy   (meas_busy),
    .tdc_clr     (tdc_clr),
    .tdc_arm     (tdc_arm),
    .start_hit   (start_hit),
    .start_fine  (start_fine),
    .stop_hit    (stop_hit),
    .stop_fine   (stop_fine),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_time    (res_time),
    .res_timeout (res_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Request a measurement; returns in the first WAIT_START cycle.
  task automatic start_meas(input string tag);
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    check({tag, "_clr"}, tdc_clr, 1);
    check({tag, "_busy"}, meas_busy, 1);
    tick();
    check({tag, "_arm"}, tdc_arm, 1);
    check({tag, "_clr_off"}, tdc_clr, 0);
  endtask

  task automatic check_result(input string tag, input logic [20:0] t, input logic to);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_time"}, res_time, t);
    check({tag, "_timeout"}, res_timeout, to);
    check({tag, "_arm_off"}, tdc_arm, 0);
  endtask

  task automatic accept(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_idle_valid"}, res_valid, 0);
    check({tag, "_idle_busy"}, meas_busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    meas_req   = 1'b0;
    start_hit  = 1'b0;
    start_fine = '0;
    stop_hit   = 1'b0;
    stop_fine  = '0;
    res_ready  = 1'b0;
    #1;
    check("rst_busy", meas_busy, 0);
    check("rst_clr", tdc_clr, 0);
    check("rst_arm", tdc_arm, 0);
    check("rst_valid", res_valid, 0);
    check("rst_timeout", res_timeout, 0);
    check("rst_time", res_time, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", meas_busy, 0);

    // Nominal: 3*32 + 20 - 7 = 109
    start_meas("nom");
    tick();
    start_hit = 1'b1; start_fine = 5'd20;
    tick();
    start_hit = 1'b0;
    check("nom_s1_valid", res_valid, 0);
    tick();
    tick();
    stop_hit = 1'b1; stop_fine = 5'd7;
    tick();
    stop_hit = 1'b0;
    check_result("nom", 21'd109, 1'b0);
    check("nom_busy", meas_busy, 1);
    accept("nom");

    // Same-cycle start/stop: 10-4 = 6
    start_meas("same_a");
    start_hit = 1'b1; start_fine = 5'd10;
    stop_hit  = 1'b1; stop_fine  = 5'd4;
    tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    check_result("same_a", 21'd6, 1'b0);
    accept("same_a");

    // Same-cycle start/stop with negative difference clamps to 0
    start_meas("same_b");
    start_hit = 1'b1; start_fine = 5'd3;
    stop_hit  = 1'b1; stop_fine  = 5'd9;
    tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    check_result("same_b", 21'd0, 1'b0);
    accept("same_b");

    // Start with no stop: timeout once coarse reaches 15 (result at S+16)
    start_meas("to_cnt");
    start_hit = 1'b1; start_fine = 5'd25;
    tick();
    start_hit = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    check("to_cnt_s15_valid", res_valid, 0);
    check("to_cnt_s15_arm", tdc_arm, 1);
    tick();
    check_result("to_cnt", 21'd0, 1'b1);
    accept("to_cnt");

    // Nonzero result first so the timeout zeroing of res_time is visible
    start_meas("pre");
    start_hit = 1'b1; start_fine = 5'd31;
    tick();
    start_hit = 1'b0;
    stop_hit = 1'b1; stop_fine = 5'd0;
    tick();
    stop_hit = 1'b0;
    check_result("pre", 21'd63, 1'b0);
    accept("pre");

    // No hits: WAIT_START entry is cycle 1, result on the 17th cycle
    start_meas("to_start");
    for (int i = 0; i < 15; i++) tick();
    check("to_st_w16_valid", res_valid, 0);
    check("to_st_w16_arm", tdc_arm, 1);
    tick();
    check_result("to_start", 21'd0, 1'b1);
    accept("to_start");

    // Stray stop before start and a second start inside COUNT are ignored
    start_meas("stray");
    stop_hit = 1'b1; stop_fine = 5'd3;
    tick();
    stop_hit = 1'b0;
    check("stray_stop_valid", res_valid, 0);
    check("stray_stop_arm", tdc_arm, 1);
    start_hit = 1'b1; start_fine = 5'd20;
    tick();
    start_hit = 1'b0;
    tick();
    start_hit = 1'b1; start_fine = 5'd31;
    tick();
    start_hit = 1'b0;
    stop_hit = 1'b1; stop_fine = 5'd7;
    tick();
    stop_hit = 1'b0;
    check_result("stray", 21'd109, 1'b0);

    // Backpressure: result held, requests ignored, including in the transfer cycle
    meas_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_time", res_time, 109);
      check("bp_timeout", res_timeout, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    meas_req  = 1'b0;
    check("bp_idle_valid", res_valid, 0);
    check("bp_idle_busy", meas_busy, 0);
    tick();
    check("bp_noqueue_busy", meas_busy, 0);
    check("bp_noqueue_clr", tdc_clr, 0);
    start_meas("bp_new");
    start_hit = 1'b1; start_fine = 5'd1;
    tick();
    start_hit = 1'b0;
    stop_hit = 1'b1; stop_fine = 5'd2;
    tick();
    stop_hit = 1'b0;
    check_result("bp_new", 21'd31, 1'b0);
    accept("bp_new");

    // Asynchronous reset in the middle of COUNT
    start_meas("rst_mid");
    start_hit = 1'b1; start_fine = 5'd12;
    tick();
    start_hit = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_busy", meas_busy, 0);
    check("rmid_arm", tdc_arm, 0);
    check("rmid_clr", tdc_clr, 0);
    check("rmid_valid", res_valid, 0);
    check("rmid_time", res_time, 0);
    check("rmid_timeout", res_timeout, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rmid_idle", meas_busy, 0);
    // 2*32 + 0 - 31 = 33
    start_meas("post_rst");
    start_hit = 1'b1; start_fine = 5'd0;
    tick();
    start_hit = 1'b0;
    tick();
    stop_hit = 1'b1; stop_fine = 5'd31;
    tick();
    stop_hit = 1'b0;
    check_result("post_rst", 21'd33, 1'b0);
    accept("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
